sha256_block_scheduler: RTL and testbench

Sequences a shared single-block SHA-256 compression core to produce the double SHA-256 of an 80-byte block header. Accepts a 640-bit header job and pads it into two 512-bit blocks. Feeds the blocks and the chaining state to the core one at a time, performs the per-block feed-forward addition, then hashes the 256-bit digest a second time. Sits between the job source (header and initial hash values) and the nonce-checking logic that consumes the final digest.

---
 rtl/sha256_pkg.sv | 43 ++++
 rtl/sha256_pad.sv | 31 +++
 rtl/sha256_block_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_sha256_block_scheduler.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared types and constants for the double SHA-256 block scheduler.
//   state_t     : scheduler FSM states
//   blk_sel_t   : which padded block the pad builder emits
//   BLOCK_W     : message block width (512)
//   STATE_W     : chaining state / digest width (256)
//   HEADER_W    : header job width (640)
//   LEN_HEADER  : bit length of the header message (640)
//   LEN_DIGEST  : bit length of the first-pass digest (256)
//   SHA256_IV   : standard SHA-256 initial hash values H0..H7
// ---------------------------------------------------------------------------
package sha256_pkg;

  localparam int BLOCK_W  = 512;
  localparam int STATE_W  = 256;
  localparam int HEADER_W = 640;

  localparam logic [63:0] LEN_HEADER = 64'd640;
  localparam logic [63:0] LEN_DIGEST = 64'd256;

  localparam logic [STATE_W-1:0] SHA256_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START1 = 3'd1,
    WAIT1  = 3'd2,
    START2 = 3'd3,
    WAIT2  = 3'd4,
    START3 = 3'd5,
    WAIT3  = 3'd6,
    OUT    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    BLK_NONE = 2'd0,
    BLK_1    = 2'd1,
    BLK_2    = 2'd2,
    BLK_3    = 2'd3
  } blk_sel_t;

endpackage

// File: rtl/sha256_pad.sv
// ---------------------------------------------------------------------------
// sha256_pad
// Combinational builder of the three padded message blocks of a double
// SHA-256 over an 80-byte header.
//   sel    in  blk_sel_t  block index (BLK_NONE drives zeros)
//   header in  640        latched header, bit 639 is the first message bit
//   d1     in  256        first-pass digest, message of the second hash
//   block  out 512        padded message block
// ---------------------------------------------------------------------------
module sha256_pad
  import sha256_pkg::*;
(
  input  blk_sel_t              sel,
  input  logic [HEADER_W-1:0]   header,
  input  logic [STATE_W-1:0]    d1,
  output logic [BLOCK_W-1:0]    block
);

  always_comb begin
    block = '0;
    case (sel)
      BLK_1:   block = header[639:128];
      // Tail of the header, the mandatory 1 bit, zero fill, 64-bit length.
      BLK_2:   block = {header[127:0], 1'b1, 319'b0, LEN_HEADER};
      // The 256-bit digest fits in one block with its padding.
      BLK_3:   block = {d1, 1'b1, 191'b0, LEN_DIGEST};
      default: block = '0;
    endcase
  end

endmodule

// File: rtl/sha256_block_scheduler.sv
// ---------------------------------------------------------------------------
// sha256_block_scheduler
// Drives a shared single-block SHA-256 compression core through the three
// compressions of a double SHA-256 over an 80-byte header: two blocks for the
// header, then one block for the resulting digest. The core returns raw
// working variables; the feed-forward additions are done here.
//
// Parameter
//   WATCHDOG       max cycles to wait for core_done per block, 0 = no timeout
// Optional feature macro
//   SHA256_MIDSTATE_EN  caches the first-block chaining value keyed by
//                       header[639:128]; a job whose first 64 bytes match
//                       skips block 1.
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   job_valid      in   header job offered
//   job_ready      out  scheduler idle and able to accept a job
//   job_header     in   640-bit header, bit 639 first
//   init_hash      in   H0..H7, H0 in bits [255:224]
//   core_start     out  one-cycle pulse launching a block on the core
//   core_block     out  512-bit block, held while the core works
//   core_state     out  256-bit chaining input, held while the core works
//   core_done      in   one-cycle pulse, core_result valid
//   core_result    in   working variables a..h after 64 rounds
//   result_valid   out  digest available
//   result_ready   in   consumer takes the digest
//   result_digest  out  double SHA-256 digest (zero on timeout)
//   result_error   out  qualifies result_valid: the core timed out
//   busy           out  scheduler not idle
// ---------------------------------------------------------------------------
module sha256_block_scheduler
  import sha256_pkg::*;
#(
  parameter int WATCHDOG = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [HEADER_W-1:0]   job_header,
  input  logic [STATE_W-1:0]    init_hash,
  output logic                  core_start,
  output logic [BLOCK_W-1:0]    core_block,
  output logic [STATE_W-1:0]    core_state,
  input  logic                  core_done,
  input  logic [STATE_W-1:0]    core_result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [STATE_W-1:0]    result_digest,
  output logic                  result_error,
  output logic                  busy
);

  // Wide enough to hold WATCHDOG itself, and never zero bits wide.
  localparam int               CNT_W    = $clog2(WATCHDOG + 2);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(WATCHDOG);
  localparam bit               WD_EN    = (WATCHDOG != 0);

  // Feed-forward: eight independent 32-bit adds, carries never cross words.
  function automatic logic [STATE_W-1:0] ff_add(input logic [STATE_W-1:0] a,
                                                input logic [STATE_W-1:0] b);
    logic [STATE_W-1:0] s;
    for (int i = 0; i < 8; i++) begin
      s[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    end
    return s;
  endfunction

  state_t               state;
  state_t               state_next;

  logic [HEADER_W-1:0]  hdr_q;
  logic [STATE_W-1:0]   iv_q;
  logic [STATE_W-1:0]   c1_q;
  logic [STATE_W-1:0]   d1_q;
  logic [STATE_W-1:0]   digest_q;
  logic                 err_q;
  logic [CNT_W-1:0]     wd_cnt;

  logic                 accept;
  logic                 in_wait;
  logic                 timeout;
  logic                 ms_hit;
  blk_sel_t             blk_sel;

`ifdef SHA256_MIDSTATE_EN
  logic [BLOCK_W-1:0]   ms_block;
  logic [STATE_W-1:0]   ms_c1;
  logic                 ms_valid;

  assign ms_hit = ms_valid && (job_header[639:128] == ms_block);
`else
  assign ms_hit = 1'b0;
`endif

  assign accept  = (state == IDLE) && job_valid;
  assign in_wait = (state == WAIT1) || (state == WAIT2) || (state == WAIT3);
  // A done arriving in the expiry cycle still wins over the timeout.
  assign timeout = WD_EN && in_wait && !core_done && (wd_cnt == WD_LIMIT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (job_valid) state_next = ms_hit ? START2 : START1;
      START1:  state_next = WAIT1;
      WAIT1:   if (core_done) state_next = START2;
               else if (timeout) state_next = OUT;
      START2:  state_next = WAIT2;
      WAIT2:   if (core_done) state_next = START3;
               else if (timeout) state_next = OUT;
      START3:  state_next = WAIT3;
      WAIT3:   if (core_done || timeout) state_next = OUT;
      OUT:     if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    job_ready    = (state == IDLE);
    busy         = (state != IDLE);
    core_start   = (state == START1) || (state == START2) || (state == START3);
    result_valid = (state == OUT);
    result_error = (state == OUT) && err_q;
    blk_sel      = BLK_NONE;
    core_state   = '0;
    case (state)
      START1, WAIT1: begin
        blk_sel    = BLK_1;
        core_state = iv_q;
      end
      START2, WAIT2: begin
        blk_sel    = BLK_2;
        core_state = c1_q;
      end
      START3, WAIT3: begin
        blk_sel    = BLK_3;
        core_state = iv_q;
      end
      default: begin
        blk_sel    = BLK_NONE;
        core_state = '0;
      end
    endcase
  end

  assign result_digest = digest_q;

  sha256_pad u_pad (
    .sel    (blk_sel),
    .header (hdr_q),
    .d1     (d1_q),
    .block  (core_block)
  );

  // Job capture, watchdog and per-block feed-forward
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_q    <= '0;
      iv_q     <= '0;
      c1_q     <= '0;
      d1_q     <= '0;
      digest_q <= '0;
      err_q    <= 1'b0;
      wd_cnt   <= '0;
`ifdef SHA256_MIDSTATE_EN
      ms_block <= '0;
      ms_c1    <= '0;
      ms_valid <= 1'b0;
`endif
    end else begin
      if (accept) begin
        hdr_q <= job_header;
        iv_q  <= init_hash;
        err_q <= 1'b0;
`ifdef SHA256_MIDSTATE_EN
        if (ms_hit) begin
          c1_q <= ms_c1;
        end
`endif
      end

      if (core_start) begin
        wd_cnt <= '0;
      end else if (in_wait && (wd_cnt != WD_LIMIT)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (in_wait && core_done) begin
        case (state)
          WAIT1: begin
            c1_q <= ff_add(iv_q, core_result);
`ifdef SHA256_MIDSTATE_EN
            ms_block <= hdr_q[639:128];
            ms_c1    <= ff_add(iv_q, core_result);
            ms_valid <= 1'b1;
`endif
          end
          WAIT2:   d1_q     <= ff_add(c1_q, core_result);
          WAIT3:   digest_q <= ff_add(iv_q, core_result);
          default: ;
        endcase
      end else if (timeout) begin
        digest_q <= '0;
        err_q    <= 1'b1;
`ifdef SHA256_MIDSTATE_EN
        ms_valid <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sha256_block_scheduler.sv
module tb_sha256_block_scheduler;
  import sha256_pkg::*;

`ifdef SHA256_MIDSTATE_EN
  localparam bit MS = 1'b1;
`else
  localparam bit MS = 1'b0;
`endif

  localparam logic [255:0] GENESIS_EXP =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  localparam logic [2047:0] KTAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [639:0] job_header = '0;
  logic [255:0] init_hash = '0;
  logic         core_start;
  logic [511:0] core_block;
  logic [255:0] core_state;
  logic         core_done = 1'b0;
  logic [255:0] core_result = '0;
  logic         result_valid;
  logic         result_ready = 1'b1;
  logic [255:0] result_digest;
  logic         result_error;
  logic         busy;

  logic         wd_job_valid = 1'b0;
  logic         wd_job_ready;
  logic [639:0] wd_header = '0;
  logic         wd_core_start;
  logic [511:0] wd_core_block;
  logic [255:0] wd_core_state;
  logic         wd_core_done = 1'b0;
  logic [255:0] wd_core_result = '0;
  logic         wd_result_valid;
  logic         wd_result_ready = 1'b1;
  logic [255:0] wd_result_digest;
  logic         wd_result_error;
  logic         wd_busy;

  int checks = 0;
  int errors = 0;
  int core_lat = 64;
  int start_cnt = 0;

  typedef struct {
    logic         err;
    logic [255:0] digest;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  sha256_block_scheduler dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_header(job_header), .init_hash(init_hash), .core_start(core_start),
    .core_block(core_block), .core_state(core_state), .core_done(core_done),
    .core_result(core_result), .result_valid(result_valid), .result_ready(result_ready),
    .result_digest(result_digest), .result_error(result_error), .busy(busy)
  );

  sha256_block_scheduler #(.WATCHDOG(16)) dut_wd (
    .clk(clk), .rst(rst), .job_valid(wd_job_valid), .job_ready(wd_job_ready),
    .job_header(wd_header), .init_hash(SHA256_IV), .core_start(wd_core_start),
    .core_block(wd_core_block), .core_state(wd_core_state), .core_done(wd_core_done),
    .core_result(wd_core_result), .result_valid(wd_result_valid), .result_ready(wd_result_ready),
    .result_digest(wd_result_digest), .result_error(wd_result_error), .busy(wd_busy)
  );

  // ---------------- reference SHA-256 ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // 64 rounds of compression, returning working variables without feed-forward.
  function automatic logic [255:0] sha_rounds(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g))
           + KTAB[2047-32*i -: 32] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a, b, c, d, e, f, g, h};
  endfunction

  // SHA-256 of a byte message (up to 80 bytes) with a caller-chosen IV.
  function automatic logic [255:0] sha256_msg(input logic [7:0] msg [0:79], input int len,
                                              input logic [255:0] iv);
    logic [7:0]   m [0:127];
    logic [63:0]  bits;
    logic [511:0] blk;
    logic [255:0] hs, r;
    int           nblk;
    for (int i = 0; i < 128; i++) m[i] = 8'h00;
    for (int i = 0; i < len; i++) m[i] = msg[i];
    m[len] = 8'h80;
    nblk = (len + 9 + 63) / 64;
    bits = 64'(len) * 64'd8;
    for (int i = 0; i < 8; i++) m[nblk*64-8+i] = bits[63-8*i -: 8];
    hs = iv;
    for (int bk = 0; bk < nblk; bk++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = m[bk*64+j];
      r = sha_rounds(hs, blk);
      for (int k = 0; k < 8; k++) hs[32*k +: 32] = hs[32*k +: 32] + r[32*k +: 32];
    end
    return hs;
  endfunction

  function automatic logic [255:0] sha256d(input logic [639:0] hdr, input logic [255:0] iv);
    logic [7:0]   msg [0:79];
    logic [255:0] h1;
    for (int i = 0; i < 80; i++) msg[i] = hdr[639-8*i -: 8];
    h1 = sha256_msg(msg, 80, iv);
    for (int i = 0; i < 80; i++) msg[i] = 8'h00;
    for (int i = 0; i < 32; i++) msg[i] = h1[255-8*i -: 8];
    return sha256_msg(msg, 32, iv);
  endfunction

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [639:0] rand_hdr();
    logic [639:0] h;
    for (int k = 0; k < 20; k++) h[32*k +: 32] = $urandom();
    return h;
  endfunction

  function automatic logic [255:0] rand_iv();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- behavioural core ----------------
  initial begin : core_model
    logic [511:0] blk;
    logic [255:0] st, res;
    forever begin
      @(negedge clk);
      if (core_start) begin
        blk = core_block;
        st  = core_state;
        res = sha_rounds(st, blk);
        @(posedge clk);
        repeat (core_lat - 1) @(posedge clk);
        #1;
        if (busy) begin
          check("core_block_stable", core_block, blk);
          check("core_state_stable", core_state, st);
        end
        core_done   = 1'b1;
        core_result = res;
        @(posedge clk);
        #1 core_done = 1'b0;
      end
    end
  end

  initial begin : start_counter
    forever begin
      @(negedge clk);
      if (core_start) start_cnt++;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid && result_ready) begin
        if (sb_q.size() == 0) begin
          bound_fail("unexpected_result");
        end else begin
          e = sb_q.pop_front();
          check("digest", result_digest, e.digest);
          check("result_error", {255'b0, result_error}, {255'b0, e.err});
        end
      end
    end
  end

  initial begin : global_limit
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [639:0] hdr, input logic [255:0] iv,
                       input logic [255:0] exp_d, input logic exp_e);
    exp_t e;
    int   n = 0;
    while (!job_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (!job_ready) bound_fail("job_ready_wait");
    job_valid  = 1'b1;
    job_header = hdr;
    init_hash  = iv;
    @(posedge clk);
    e.err = exp_e;
    e.digest = exp_d;
    sb_q.push_back(e);
    start_cnt = 0;
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!result_valid && lat < 2000) begin
      @(posedge clk); #1; lat++;
    end
    if (!result_valid) bound_fail("result_valid_wait");
  endtask

  initial begin : main
    logic [639:0] gen_hdr, hdr, hdr2;
    logic [255:0] iv, exp_d;
    int           lat, n;

    gen_hdr = {32'h01000000, 256'h0,
               256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
               32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};

    repeat (3) @(posedge clk);
    #1;
    check("rst_job_ready", {255'b0, job_ready}, 256'd1);
    check("rst_busy", {255'b0, busy}, 256'd0);
    check("rst_core_start", {255'b0, core_start}, 256'd0);
    check("rst_result_valid", {255'b0, result_valid}, 256'd0);
    check("rst_result_error", {255'b0, result_error}, 256'd0);
    check("rst_core_block", core_block[255:0] | core_block[511:256], 256'd0);
    check("rst_core_state", core_state, 256'd0);
    check("rst_result_digest", result_digest, 256'd0);
    check("rst_wd_job_ready", {255'b0, wd_job_ready}, 256'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Genesis header, 64-cycle core
    core_lat = 64;
    issue(gen_hdr, SHA256_IV, GENESIS_EXP, 1'b0);
    wait_valid(lat);
    check("genesis_lat64_latency", lat, 3 + 3 * 64);
    check("genesis_lat64_starts", start_cnt, 3);
    @(posedge clk); #1;

    // Same job, 1-cycle core (a cached midstate skips block 1)
    core_lat = 1;
    issue(gen_hdr, SHA256_IV, GENESIS_EXP, 1'b0);
    wait_valid(lat);
    check("genesis_lat1_latency", lat, MS ? 4 : 6);
    check("genesis_lat1_starts", start_cnt, MS ? 2 : 3);
    @(posedge clk); #1;

    // Random headers, IVs, core latencies and backpressure
    for (int i = 0; i < 8; i++) begin
      hdr = rand_hdr();
      iv  = (i % 2 == 1) ? rand_iv() : SHA256_IV;
      core_lat = $urandom_range(1, 40);
      result_ready = (i % 3 != 0);
      issue(hdr, iv, sha256d(hdr, iv), 1'b0);
      wait_valid(lat);
      check("random_latency", lat, 3 + 3 * core_lat);
      check("random_starts", start_cnt, 3);
      if (!result_ready) begin
        repeat ($urandom_range(1, 5)) begin
          @(posedge clk); #1;
        end
        result_ready = 1'b1;
      end
      @(posedge clk); #1;
    end

    // Hold the result for 10 cycles; a job offered meanwhile is ignored
    core_lat = 3;
    hdr = rand_hdr();
    exp_d = sha256d(hdr, SHA256_IV);
    result_ready = 1'b0;
    issue(hdr, SHA256_IV, exp_d, 1'b0);
    wait_valid(lat);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        job_valid  = 1'b1;
        job_header = rand_hdr();
      end
      if (k == 4) job_valid = 1'b0;
      @(posedge clk); #1;
      check("hold_digest", result_digest, exp_d);
      check("hold_valid", {255'b0, result_valid}, 256'd1);
      check("hold_job_ready", {255'b0, job_ready}, 256'd0);
    end
    check("hold_starts", start_cnt, 3);
    result_ready = 1'b1;
    @(posedge clk); #1;
    check("post_handshake_job_ready", {255'b0, job_ready}, 256'd1);
    check("post_handshake_busy", {255'b0, busy}, 256'd0);

    // Reset while waiting on the second block; the late done is ignored
    core_lat = 20;
    hdr = rand_hdr();
    issue(hdr, SHA256_IV, sha256d(hdr, SHA256_IV), 1'b0);
    n = 0;
    while (start_cnt < 2 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (start_cnt < 2) bound_fail("reach_wait2");
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("midrst_job_ready", {255'b0, job_ready}, 256'd1);
    check("midrst_busy", {255'b0, busy}, 256'd0);
    check("midrst_core_start", {255'b0, core_start}, 256'd0);
    check("midrst_result_valid", {255'b0, result_valid}, 256'd0);
    check("midrst_result_error", {255'b0, result_error}, 256'd0);
    check("midrst_core_block", core_block[255:0] | core_block[511:256], 256'd0);
    check("midrst_core_state", core_state, 256'd0);
    check("midrst_result_digest", result_digest, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
    end
    check("late_done_busy", {255'b0, busy}, 256'd0);
    check("late_done_job_ready", {255'b0, job_ready}, 256'd1);
    check("late_done_result_valid", {255'b0, result_valid}, 256'd0);
    check("late_done_starts", start_cnt, 2);

    // Watchdog instance: the core never answers
    wd_header = gen_hdr;
    wd_job_valid = 1'b1;
    @(posedge clk); #1;
    wd_job_valid = 1'b0;
    check("wd_core_start", {255'b0, wd_core_start}, 256'd1);
    check("wd_busy", {255'b0, wd_busy}, 256'd1);
    check("wd_core_block_hi", wd_core_block[511:256], gen_hdr[639:384]);
    check("wd_core_block_lo", wd_core_block[255:0], gen_hdr[383:128]);
    check("wd_core_state", wd_core_state, SHA256_IV);
    lat = 0;
    while (!wd_result_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!wd_result_valid) bound_fail("wd_result_valid_wait");
    check("wd_latency", lat, 18);
    check("wd_result_error", {255'b0, wd_result_error}, 256'd1);
    check("wd_result_digest", wd_result_digest, 256'd0);
    check("wd_job_ready_in_out", {255'b0, wd_job_ready}, 256'd0);
    @(posedge clk); #1;
    check("wd_job_ready_after", {255'b0, wd_job_ready}, 256'd1);

    // Two jobs differing only in the nonce
    core_lat = 2;
    hdr  = rand_hdr();
    hdr2 = hdr;
    hdr2[31:0] = hdr[31:0] ^ 32'h0000_0001;
    issue(hdr, SHA256_IV, sha256d(hdr, SHA256_IV), 1'b0);
    wait_valid(lat);
    check("nonce_a_latency", lat, 3 + 3 * 2);
    check("nonce_a_starts", start_cnt, 3);
    @(posedge clk); #1;
    issue(hdr2, SHA256_IV, sha256d(hdr2, SHA256_IV), 1'b0);
    wait_valid(lat);
    check("nonce_b_latency", lat, MS ? (2 + 2 * 2) : (3 + 3 * 2));
    check("nonce_b_starts", start_cnt, MS ? 2 : 3);
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
